// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the pipeline hazard/stall controller slice:
// register-index width, memory-wait FSM encoding and watchdog default.
package hazard_stall_controller_pkg;

    localparam int REG_W            = 4;
    localparam int DEFAULT_MAX_WAIT = 15;
    localparam int WAIT_W           = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle of ID/EXE/MEM hazard inputs and pipeline freeze/flush controls.
// The master side drives the pipeline status; the slave side is the controller.
interface hazard_stall_controller_if
    import hazard_stall_controller_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             forwardEnIn;
    logic             twoSrcIn;
    logic [REG_W-1:0] src1In;
    logic [REG_W-1:0] src2In;
    logic             EXE_WB_ENIn;
    logic             EXE_MEM_R_ENIn;
    logic [REG_W-1:0] EXE_DestIn;
    logic             MEM_WB_ENIn;
    logic [REG_W-1:0] MEM_DestIn;
    logic             branchTakenIn;
    logic             memReqIn;
    logic             memReadyIn;
    logic             cntClrIn;
    logic             freezePCOut;
    logic             freezeIFIDOut;
    logic             bubbleIDEXOut;
    logic             flushIFIDOut;
    logic             freezeAllOut;
    logic             memErrOut;
    logic [CNT_W-1:0] stallCntOut;

    modport master (
        output forwardEnIn, twoSrcIn, src1In, src2In,
        output EXE_WB_ENIn, EXE_MEM_R_ENIn, EXE_DestIn,
        output MEM_WB_ENIn, MEM_DestIn,
        output branchTakenIn, memReqIn, memReadyIn, cntClrIn,
        input  freezePCOut, freezeIFIDOut, bubbleIDEXOut, flushIFIDOut,
        input  freezeAllOut, memErrOut, stallCntOut
    );

    modport slave (
        input  forwardEnIn, twoSrcIn, src1In, src2In,
        input  EXE_WB_ENIn, EXE_MEM_R_ENIn, EXE_DestIn,
        input  MEM_WB_ENIn, MEM_DestIn,
        input  branchTakenIn, memReqIn, memReadyIn, cntClrIn,
        output freezePCOut, freezeIFIDOut, bubbleIDEXOut, flushIFIDOut,
        output freezeAllOut, memErrOut, stallCntOut
    );

endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear, usable for any performance
// event; clear wins over increment and the count sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush sequencer: RAW and load-use detection, taken-branch
// squash, SRAM wait tracking with a watchdog, and a stall-cycle counter.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int CNT_W    = 16
) (
    input logic                    clk,
    input logic                    rst,
    hazard_stall_controller_if.slave bus
);

    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

    mem_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_err;
    logic              mem_stall;
    logic              exe_match;
    logic              mem_match;
    logic              raw_haz;
    logic              stall_event;

    always_comb begin
        exe_match = (bus.EXE_DestIn == bus.src1In) ||
                    (bus.twoSrcIn && (bus.EXE_DestIn == bus.src2In));
        mem_match = (bus.MEM_DestIn == bus.src1In) ||
                    (bus.twoSrcIn && (bus.MEM_DestIn == bus.src2In));
        if (bus.forwardEnIn) begin
            raw_haz = bus.EXE_WB_ENIn && bus.EXE_MEM_R_ENIn && exe_match;
        end else begin
            raw_haz = (bus.EXE_WB_ENIn && exe_match) ||
                      (bus.MEM_WB_ENIn && mem_match);
        end
    end

    // The final BUSY cycle (ready or watchdog expiry) lets the pipeline move.
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            IDLE: mem_stall = bus.memReqIn;
            BUSY: mem_stall = !bus.memReadyIn && (wait_cnt != LAST_WAIT);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.memReqIn) begin
                        state    <= BUSY;
                        wait_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (bus.memReadyIn) begin
                        state <= IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Memory stall masks everything; a branch squashes the ID instruction,
    // so any hazard it carried no longer matters.
    always_comb begin
        bus.freezeAllOut  = 1'b0;
        bus.freezePCOut   = 1'b0;
        bus.freezeIFIDOut = 1'b0;
        bus.bubbleIDEXOut = 1'b0;
        bus.flushIFIDOut  = 1'b0;
        if (mem_stall) begin
            bus.freezeAllOut = 1'b1;
        end else if (bus.branchTakenIn) begin
            bus.flushIFIDOut  = 1'b1;
            bus.bubbleIDEXOut = 1'b1;
        end else if (raw_haz) begin
            bus.freezePCOut   = 1'b1;
            bus.freezeIFIDOut = 1'b1;
            bus.bubbleIDEXOut = 1'b1;
        end
    end

    assign stall_event   = bus.freezeAllOut || bus.freezePCOut;
    assign bus.memErrOut = mem_err;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_event),
        .clr   (bus.cntClrIn),
        .count (bus.stallCntOut)
    );

endmodule
